// File: rtl/if_pkg.sv
// if_pkg: shared constants and fetch-buffer entry type for the instruction-fetch stage.
package if_pkg;
    localparam logic [31:0] BOOT_ROM_BASE = 32'hFFFFF000;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        filled;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: circular buffer of fetch entries, allocated and filled in order, popped from the head.
module fetch_buffer
    import if_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          alloc,
    input  logic [31:0]   alloc_pc,
    input  logic          fill,
    input  logic [31:0]   fill_data,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic [CW-1:0] unfilled
);
    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] hd, tl, fp;

    assign head = mem[hd];

    // alloc and fill never target the same slot: fill only touches entries already allocated
    always_ff @(posedge clk) begin
        if (alloc)
            mem[tl] <= '{pc: alloc_pc, instr: '0, filled: 1'b0};
        if (fill) begin
            mem[fp].instr  <= fill_data;
            mem[fp].filled <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            {hd, tl, fp, count, unfilled} <= '0;
        else if (flush)
            {hd, tl, fp, count, unfilled} <= '0;
        else begin
            hd       <= hd + PW'(pop);
            tl       <= tl + PW'(alloc);
            fp       <= fp + PW'(fill);
            count    <= count + CW'(alloc) - CW'(pop);
            unfilled <= unfilled + CW'(alloc) - CW'(fill);
        end
    end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: IF1/IF2 fetch controller; issues credit-limited in-order imem requests,
// steers the PC register and discards responses left in flight by a redirect.
module fetch_sequencer #(
    parameter int DEPTH       = 4,
    parameter int INSTR_BYTES = if_pkg::INSTR_BYTES
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] current_pc_if1,
    output logic [31:0] next_pc_if1,
    output logic        pc_en,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);
    import if_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic          run, redir, accept, fill, pop, rsp_drop;
    logic [CW-1:0] count, unfilled, drop_cnt;
    fetch_entry_t  head;

    assign redir          = run & redirect_valid;
    assign imem_req_valid = run & ~redirect_valid &
                            (({1'b0, count} + {1'b0, drop_cnt}) < (CW+1)'(DEPTH));
    assign imem_req_addr  = current_pc_if1;
    assign accept         = imem_req_valid & imem_req_ready;
    assign pc_en          = accept | redir;
    assign next_pc_if1    = redir ? redirect_pc : current_pc_if1 + 32'(INSTR_BYTES);

    // a response colliding with a redirect belongs to an entry being flushed, so it is consumed as stale
    assign rsp_drop = imem_rsp_valid & ((drop_cnt != '0) | (redir & (unfilled != '0)));
    assign fill     = imem_rsp_valid & ~redir & (drop_cnt == '0) & (unfilled != '0);

    assign inst_valid = (count != '0) & head.filled;
    assign inst_data  = head.instr;
    assign inst_pc    = head.pc;
    assign pop        = inst_valid & inst_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            run      <= 1'b1;
            drop_cnt <= drop_cnt + (redir ? unfilled : '0) - CW'(rsp_drop);
        end
    end

    fetch_buffer #(.DEPTH(DEPTH)) u_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .alloc     (accept),
        .alloc_pc  (current_pc_if1),
        .fill      (fill),
        .fill_data (imem_rsp_data),
        .pop       (pop),
        .flush     (redir),
        .head      (head),
        .count     (count),
        .unfilled  (unfilled)
    );

    assert property (@(posedge clk) disable iff (!reset_n)
        !(imem_rsp_valid && drop_cnt == '0 && unfilled == '0));
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed tests of fetch_sequencer against a PC register and in-order imem model.
module tb_fetch_sequencer;
    import if_pkg::*;

    logic        clk = 0, reset_n = 0;
    logic [31:0] current_pc_if1, next_pc_if1, imem_req_addr, imem_rsp_data, inst_data, inst_pc;
    logic        pc_en, imem_req_valid, imem_rsp_valid, inst_valid;
    logic        imem_req_ready = 0, redirect_valid = 0, inst_ready = 0, rsp_en = 1;
    logic [31:0] redirect_pc = '0;
    logic        rsp_pend;
    logic [31:0] rsp_word;
    logic [31:0] req_q[$], got_pc[$], got_data[$];
    int          n_acc, errors = 0, checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A5A0F0F;
    endfunction

    fetch_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .current_pc_if1 (current_pc_if1),
        .next_pc_if1    (next_pc_if1),
        .pc_en          (pc_en),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    always @(posedge clk or negedge reset_n)
        if (!reset_n) current_pc_if1 <= BOOT_ROM_BASE;
        else if (pc_en) current_pc_if1 <= next_pc_if1;

    assign imem_rsp_valid = rsp_en & rsp_pend;
    assign imem_rsp_data  = rsp_word;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q.delete();
            got_pc.delete();
            got_data.delete();
            n_acc = 0;
            rsp_pend <= 1'b0;
            rsp_word <= '0;
        end else begin
            if (imem_rsp_valid) void'(req_q.pop_front());
            if (imem_req_valid && imem_req_ready) begin
                req_q.push_back(imem_req_addr);
                n_acc++;
            end
            if (inst_valid && inst_ready) begin
                got_pc.push_back(inst_pc);
                got_data.push_back(inst_data);
            end
            rsp_pend <= req_q.size() != 0;
            rsp_word <= req_q.size() != 0 ? word(req_q[0]) : '0;
        end
    end

    task automatic do_reset();
        reset_n = 0; imem_req_ready = 0; inst_ready = 0; redirect_valid = 0; rsp_en = 1;
        repeat (2) @(negedge clk);
        reset_n = 1;
    endtask

    task automatic test_reset();
        reset_n = 0; imem_req_ready = 1; inst_ready = 1; redirect_valid = 0; rsp_en = 1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({imem_req_valid, pc_en, inst_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: req_valid/pc_en/inst_valid=%b expected 000",
                     {imem_req_valid, pc_en, inst_valid});
        end
        @(negedge clk);
        reset_n = 1;
        #1;
        checks++;
        if ({imem_req_valid, pc_en} !== 2'b00) begin
            errors++;
            $display("FAIL first_cycle: req_valid/pc_en=%b expected 00", {imem_req_valid, pc_en});
        end
        @(negedge clk);
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== BOOT_ROM_BASE) begin
            errors++;
            $display("FAIL first_request: valid=%b addr=%h expected 1 %h",
                     imem_req_valid, imem_req_addr, BOOT_ROM_BASE);
        end
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_early_inst: inst_valid=%b expected 0", inst_valid);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        int          n;
        do_reset();
        imem_req_ready = 1; inst_ready = 1;
        n = 0;
        @(negedge clk); #1;
        while (!inst_valid && n < 10) begin
            @(negedge clk); #1;
            n++;
        end
        exp_pc = BOOT_ROM_BASE;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst_data !== word(exp_pc)) begin
                errors++;
                $display("FAIL stream_%0d: valid=%b pc=%h data=%h expected 1 %h %h",
                         k, inst_valid, inst_pc, inst_data, exp_pc, word(exp_pc));
            end
            exp_pc += 4;
            @(negedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        imem_req_ready = 1; inst_ready = 0;
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (n_acc !== 4 || imem_req_valid !== 1'b0 || pc_en !== 1'b0) begin
            errors++;
            $display("FAIL credit_limit: accepted=%0d valid=%b pc_en=%b expected 4 0 0",
                     n_acc, imem_req_valid, pc_en);
        end
        checks++;
        if (current_pc_if1 !== 32'hFFFFF010) begin
            errors++;
            $display("FAIL pc_held: pc=%h expected fffff010", current_pc_if1);
        end
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== BOOT_ROM_BASE) begin
            errors++;
            $display("FAIL held_head: valid=%b pc=%h expected 1 %h", inst_valid, inst_pc, BOOT_ROM_BASE);
        end
        @(negedge clk);
        inst_ready = 1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL pop_precount: valid=%b expected 0", imem_req_valid);
        end
        @(negedge clk); #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFFF010 || pc_en !== 1'b1) begin
            errors++;
            $display("FAIL resume: valid=%b addr=%h pc_en=%b expected 1 fffff010 1",
                     imem_req_valid, imem_req_addr, pc_en);
        end
    endtask

    task automatic test_redirect();
        int old;
        do_reset();
        rsp_en = 0; inst_ready = 1;
        @(negedge clk);
        imem_req_ready = 1;
        repeat (2) @(negedge clk);
        imem_req_ready = 0; redirect_valid = 1; redirect_pc = 32'h80000000;
        #1;
        checks++;
        if (n_acc !== 2 || pc_en !== 1'b1 || next_pc_if1 !== 32'h80000000 || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_pc: acc=%0d pc_en=%b next=%h valid=%b expected 2 1 80000000 0",
                     n_acc, pc_en, next_pc_if1, imem_req_valid);
        end
        @(negedge clk);
        redirect_valid = 0; rsp_en = 1; imem_req_ready = 1;
        #1;
        checks++;
        if (inst_valid !== 1'b0 || current_pc_if1 !== 32'h80000000) begin
            errors++;
            $display("FAIL after_flush: inst_valid=%b pc=%h expected 0 80000000", inst_valid, current_pc_if1);
        end
        repeat (12) @(negedge clk);
        checks++;
        if (got_pc.size() == 0 || got_pc[0] !== 32'h80000000 || got_data[0] !== word(32'h80000000)) begin
            errors++;
            $display("FAIL redirect_first: count=%0d pc=%h data=%h expected 80000000 %h",
                     got_pc.size(), got_pc.size() ? got_pc[0] : 32'h0,
                     got_data.size() ? got_data[0] : 32'h0, word(32'h80000000));
        end
        old = 0;
        foreach (got_pc[i]) if (got_pc[i][31:12] == 20'hFFFFF) old++;
        checks++;
        if (old != 0) begin
            errors++;
            $display("FAIL stale_delivered: old=%0d expected 0", old);
        end
    endtask

    task automatic test_req_stall();
        do_reset();
        inst_ready = 1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (pc_en !== 1'b0 || current_pc_if1 !== BOOT_ROM_BASE || imem_req_addr !== BOOT_ROM_BASE
                || imem_req_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_%0d: pc_en=%b pc=%h addr=%h valid=%b expected 0 %h %h 1",
                         i, pc_en, current_pc_if1, imem_req_addr, imem_req_valid,
                         BOOT_ROM_BASE, BOOT_ROM_BASE);
            end
            @(negedge clk);
        end
        imem_req_ready = 1;
        #1;
        checks++;
        if (pc_en !== 1'b1 || next_pc_if1 !== 32'hFFFFF004) begin
            errors++;
            $display("FAIL stall_release: pc_en=%b next=%h expected 1 fffff004", pc_en, next_pc_if1);
        end
    endtask

    task automatic test_redirect_wrap();
        int old;
        do_reset();
        inst_ready = 1;
        @(negedge clk);
        imem_req_ready = 1;
        @(negedge clk);
        imem_req_ready = 0; redirect_valid = 1; redirect_pc = 32'hFFFFFFFC;
        #1;
        checks++;
        if (imem_rsp_valid !== 1'b1 || pc_en !== 1'b1 || next_pc_if1 !== 32'hFFFFFFFC) begin
            errors++;
            $display("FAIL collide_redirect: rsp=%b pc_en=%b next=%h expected 1 1 fffffffc",
                     imem_rsp_valid, pc_en, next_pc_if1);
        end
        @(negedge clk);
        redirect_valid = 0; imem_req_ready = 1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFFFFFC || pc_en !== 1'b1
            || next_pc_if1 !== 32'h00000000) begin
            errors++;
            $display("FAIL wrap: valid=%b addr=%h pc_en=%b next=%h expected 1 fffffffc 1 00000000",
                     imem_req_valid, imem_req_addr, pc_en, next_pc_if1);
        end
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL collide_dropped: inst_valid=%b expected 0", inst_valid);
        end
        @(negedge clk); #1;
        checks++;
        if (current_pc_if1 !== 32'h0 || imem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrapped_pc: pc=%h addr=%h expected 00000000", current_pc_if1, imem_req_addr);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (got_pc.size() < 2 || got_pc[0] !== 32'hFFFFFFFC || got_pc[1] !== 32'h0
            || got_data[0] !== word(32'hFFFFFFFC)) begin
            errors++;
            $display("FAIL wrap_delivery: count=%0d pc0=%h pc1=%h expected fffffffc 00000000",
                     got_pc.size(), got_pc.size() > 0 ? got_pc[0] : 32'h0,
                     got_pc.size() > 1 ? got_pc[1] : 32'h0);
        end
        old = 0;
        foreach (got_pc[i]) if (got_pc[i] == BOOT_ROM_BASE) old++;
        checks++;
        if (old != 0) begin
            errors++;
            $display("FAIL collide_stale: old=%0d expected 0", old);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_req_stall();
        test_redirect_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete within 200000 time units");
        $fatal(1);
    end
endmodule
